zuc256_mac_sched: RTL
=====================

Name: zuc256_mac_sched

Overview:
- Sequencer that runs one complete ZUC-256 MAC computation over a message of arbitrary bit length.
- Issues the MAC engine's init, next and final commands in order and splits the incoming 128-bit block stream.
- Masks the trailing partial block to the message length, then returns the tag with a done pulse.
- Sits between the message source (DMA/stream) and zuc256_mac; owns every MAC command strobe.

Parameters:
- MSG_LEN_W, 16, width of message length in bits (max message 2^MSG_LEN_W - 1 bits)
- TIMEOUT, 4096, watchdog limit in cycles per MAC command (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- key  in  256  MAC key; captured on accepted start
- iv  in  128  MAC IV; captured on accepted start
- tag_len  in  8  32, 64 or 128; captured on accepted start
- msg_len  in  MSG_LEN_W  message length in bits; captured on accepted start
- blk_data  in  128  message block, MSB = first message bit
- blk_valid  in  1  blk_data valid
- blk_ready  out  1  block accepted when blk_valid && blk_ready
- mac_init  out  1  one-cycle command pulse to MAC
- mac_next  out  1  one-cycle command pulse to MAC
- mac_final  out  1  one-cycle command pulse to MAC
- mac_key  out  256  captured key
- mac_iv  out  128  captured iv
- mac_tag_len  out  8  captured tag_len
- mac_block  out  128  masked block register
- mac_i_len  out  8  remainder bits for final
- mac_tag  in  128  MAC tag
- mac_ready  in  1  MAC completion pulse (one cycle per command)
- tag  out  128  result; low tag_len bits valid, upper bits zero
- tag_valid  out  1  one-cycle pulse when tag is updated
- busy  out  1  high from accepted start until DONE exits
- error  out  1  sticky until next accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, captured registers 0. Reset mid-operation aborts immediately; no pulses are emitted afterwards.
- Derived counts at start: nblk = ceil(msg_len/128); r = msg_len[6:0]; mac_i_len = {1'b0, r}.
- States: IDLE, CMD_INIT, WAIT_INIT, FETCH, CMD_NEXT, WAIT_NEXT, CMD_FINAL, WAIT_FINAL, DONE.
- IDLE: on start, capture inputs, clear error, set busy, go to CMD_INIT.
  - If the captured tag_len is not 32, 64 or 128, set error, issue no commands and go to DONE with tag = 0.
- CMD_INIT: mac_init for exactly one cycle, then WAIT_INIT.
- WAIT_INIT: on mac_ready, go to FETCH if blocks_left != 0, else CMD_FINAL.
- FETCH: blk_ready = 1. On handshake:
  - mac_block = blk_data, except on the last block with r != 0, where bits [127-r:0] are forced to 0.
  - Decrement blocks_left, then go to CMD_NEXT.
- CMD_NEXT: mac_next for exactly one cycle, then WAIT_NEXT.
- WAIT_NEXT: on mac_ready, go to FETCH if blocks_left != 0, else CMD_FINAL.
- CMD_FINAL: mac_final for one cycle; mac_i_len is held stable. Then WAIT_FINAL.
- WAIT_FINAL: on mac_ready, register the tag, then go to DONE:
  - tag_len 32: tag = {96'h0, mac_tag[31:0]}
  - tag_len 64: tag = {64'h0, mac_tag[63:0]}
  - tag_len 128: tag = mac_tag
- DONE: tag_valid = 1 for one cycle, busy = 0 on the next cycle, return to IDLE.
- blk_ready is asserted only in FETCH. blk_valid outside FETCH is ignored and never consumed.
- mac_ready arriving outside a WAIT state is ignored.
- start while busy is ignored.
- At most one MAC command is outstanding at any time; command pulses never overlap.
- msg_len = 0: init, then final with i_len = 0; no next, no block consumed.
- Exact multiple of 128: no masking; i_len = 0.
- blocks_left is MSG_LEN_W-6 bits wide, so no overflow at maximum length.
- mac_key, mac_iv, mac_tag_len and mac_block are stable from the command pulse through the matching mac_ready.

Optional Feature:
- Macro ZUC256_SCHED_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on each command pulse and increments in every WAIT state.
  - When it reaches TIMEOUT with no mac_ready: set error, go to DONE, tag = 0, tag_valid pulses.
  - FETCH is not timed.
- Not defined: no counter; WAIT states wait indefinitely and error flags only an illegal tag_len.

Test Plan:
- msg_len=256, tag_len=128, two blocks, model MAC ready 5 cycles after each command -> exactly 1 init, 2 next, 1 final; i_len=0; no masking; tag=model tag; one tag_valid pulse; busy low after.
- msg_len=200, tag_len=32, blocks A,B -> second mac_block = B with bits [55:0] zeroed; i_len=72; tag = {96'h0, mac_tag[31:0]}.
- msg_len=0, tag_len=64 -> init then final, i_len=0; blk_ready never asserted; tag = {64'h0, mac_tag[63:0]}.
- tag_len=48 -> no MAC pulses; error=1; tag_valid pulse with tag=0. Then a legal start -> error cleared on accept.
- blk_valid withheld 20 cycles in FETCH, start pulsed mid-run, then reset asserted during WAIT_NEXT -> no mac_next until data arrives; start ignored; after reset all outputs 0 and no further pulses.
- With ZUC256_SCHED_WATCHDOG_EN, TIMEOUT=16, MAC never returns ready after next -> error=1 and tag_valid 16 cycles after the mac_next pulse.

Source files
------------

// File: rtl/zuc256_mac_sched.sv
// ---------------------------------------------------------------------------
// zuc256_mac_sched
//
// Sequencer for one complete ZUC-256 MAC computation over a message of any
// bit length. It issues the MAC engine's init / next / final commands in
// order, splits the incoming 128-bit block stream into per-command blocks,
// masks the trailing partial block to the message length and returns the
// tag with a one-cycle tag_valid pulse.
//
// Optional feature (compile-time macro ZUC256_SCHED_WATCHDOG_EN):
//   A per-command watchdog that aborts with error=1 and tag=0 when the MAC
//   fails to answer within TIMEOUT cycles. Without the macro the WAIT states
//   wait indefinitely.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             one-cycle request, sampled only when idle
//   key, iv, tag_len,
//   msg_len           job parameters, captured on an accepted start
//   blk_data/valid/
//   blk_ready         message block stream (MSB = first message bit)
//   mac_init/next/
//   mac_final         one-cycle command pulses to the MAC engine
//   mac_key, mac_iv,
//   mac_tag_len,
//   mac_block,
//   mac_i_len         operands held stable for the MAC engine
//   mac_tag, mac_ready
//                     MAC result and per-command completion pulse
//   tag, tag_valid    result (low tag_len bits valid) and its update pulse
//   busy              high from accepted start until DONE exits
//   error             sticky until the next accepted start
// ---------------------------------------------------------------------------
module zuc256_mac_sched #(
   parameter int unsigned MSG_LEN_W = 16,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [255:0]         key,
   input  logic [127:0]         iv,
   input  logic [7:0]           tag_len,
   input  logic [MSG_LEN_W-1:0] msg_len,
   input  logic [127:0]         blk_data,
   input  logic                 blk_valid,
   output logic                 blk_ready,
   output logic                 mac_init,
   output logic                 mac_next,
   output logic                 mac_final,
   output logic [255:0]         mac_key,
   output logic [127:0]         mac_iv,
   output logic [7:0]           mac_tag_len,
   output logic [127:0]         mac_block,
   output logic [7:0]           mac_i_len,
   input  logic [127:0]         mac_tag,
   input  logic                 mac_ready,
   output logic [127:0]         tag,
   output logic                 tag_valid,
   output logic                 busy,
   output logic                 error
);

   // ceil((2^MSG_LEN_W - 1) / 128) needs MSG_LEN_W-6 bits.
   localparam int unsigned BL_W = MSG_LEN_W - 6;

   typedef enum logic [3:0] {
      IDLE,
      CMD_INIT,
      WAIT_INIT,
      FETCH,
      CMD_NEXT,
      WAIT_NEXT,
      CMD_FINAL,
      WAIT_FINAL,
      DONE
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [BL_W-1:0] blocks_left_q;
   logic [BL_W-1:0] nblk;
   logic            tag_len_legal;
   logic            last_partial;
   logic [127:0]    keep_mask;
   logic [127:0]    tag_fmt;
   logic            wd_expired;

   assign nblk          = BL_W'(msg_len[MSG_LEN_W-1:7]) + BL_W'(|msg_len[6:0]);
   assign tag_len_legal = (tag_len == 8'd32) || (tag_len == 8'd64) || (tag_len == 8'd128);

   // The final block is partial when the remainder r = mac_i_len is nonzero;
   // only its top r bits carry message data.
   assign last_partial  = (blocks_left_q == BL_W'(1)) && (mac_i_len[6:0] != 7'd0);
   assign keep_mask     = ~({128{1'b1}} >> mac_i_len[6:0]);

   always_comb begin
      case (mac_tag_len)
         8'd32:   tag_fmt = {96'h0, mac_tag[31:0]};
         8'd64:   tag_fmt = {64'h0, mac_tag[63:0]};
         default: tag_fmt = mac_tag;
      endcase
   end

   // Config sanity: a watchdog shorter than two cycles cannot tell a command
   // pulse from its timeout.
   timeout_legal_a: assert property (@(posedge clk) disable iff (reset) TIMEOUT >= 2);

`ifdef ZUC256_SCHED_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_cnt_q;
   logic            in_wait;
   logic            cmd_pulse;

   assign in_wait   = (state_q == WAIT_INIT) || (state_q == WAIT_NEXT) || (state_q == WAIT_FINAL);
   assign cmd_pulse = mac_init || mac_next || mac_final;

   // The command cycle counts as the first elapsed cycle, so the abort lands
   // exactly TIMEOUT cycles after the command pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt_q <= '0;
      end else if (cmd_pulse) begin
         wd_cnt_q <= WD_W'(1);
      end else if (in_wait) begin
         wd_cnt_q <= wd_cnt_q + WD_W'(1);
      end
   end

   assign wd_expired = in_wait && (wd_cnt_q == WD_W'(TIMEOUT - 1));
`else
   assign wd_expired = 1'b0;
`endif

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others; blocking here would create ordering races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and command strobes.
   // NOTE: every output of this block gets a default first so no path leaves
   // a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      blk_ready = 1'b0;
      mac_init  = 1'b0;
      mac_next  = 1'b0;
      mac_final = 1'b0;
      tag_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = tag_len_legal ? CMD_INIT : DONE;
            end
         end
         CMD_INIT: begin
            mac_init = 1'b1;
            state_d  = WAIT_INIT;
         end
         WAIT_INIT, WAIT_NEXT: begin
            // A completing mac_ready wins over a simultaneous watchdog expiry.
            if (mac_ready) begin
               state_d = (blocks_left_q != '0) ? FETCH : CMD_FINAL;
            end else if (wd_expired) begin
               state_d = DONE;
            end
         end
         FETCH: begin
            blk_ready = 1'b1;
            if (blk_valid) begin
               state_d = CMD_NEXT;
            end
         end
         CMD_NEXT: begin
            mac_next = 1'b1;
            state_d  = WAIT_NEXT;
         end
         CMD_FINAL: begin
            mac_final = 1'b1;
            state_d   = WAIT_FINAL;
         end
         WAIT_FINAL: begin
            if (mac_ready || wd_expired) begin
               state_d = DONE;
            end
         end
         DONE: begin
            tag_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   // Captured operands, block register, tag and error flag. Operands only
   // change on an accepted start or a block handshake, so they stay stable
   // from each command pulse through its mac_ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mac_key       <= '0;
         mac_iv        <= '0;
         mac_tag_len   <= '0;
         mac_i_len     <= '0;
         mac_block     <= '0;
         blocks_left_q <= '0;
         tag           <= '0;
         error         <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mac_key       <= key;
                  mac_iv        <= iv;
                  mac_tag_len   <= tag_len;
                  mac_i_len     <= {1'b0, msg_len[6:0]};
                  blocks_left_q <= nblk;
                  tag           <= '0;
                  error         <= !tag_len_legal;
               end
            end
            FETCH: begin
               if (blk_valid) begin
                  mac_block     <= last_partial ? (blk_data & keep_mask) : blk_data;
                  blocks_left_q <= blocks_left_q - BL_W'(1);
               end
            end
            WAIT_FINAL: begin
               if (mac_ready) begin
                  tag <= tag_fmt;
               end
            end
            default: ;
         endcase
         // Tag stays at the zero written on start when the watchdog fires.
         if (wd_expired && !mac_ready) begin
            error <= 1'b1;
         end
      end
   end

endmodule
